// File: rtl/controle_senha.sv
// Combination-lock sequencer: debounces the entry button, checks six-digit
// attempts against a programmable code, counts failures and enforces a lockout.
module controle_senha #(
  parameter int                     N_DIGITOS     = 6,
  parameter logic [4*N_DIGITOS-1:0] SENHA_INICIAL = 24'h590981,
  parameter int                     MAX_FALHAS    = 3,
  parameter int                     T_BLOQUEIO    = 50_000_000,
  parameter int                     DEBOUNCE      = 250_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              insere,
  input  logic                              programa,
  input  logic [4:1]                        numero,
  output logic                              aberto,
  output logic                              bloqueado,
  output logic                              erro,
  output logic                              programando,
  output logic                              invalido,
  output logic [2:0]                        digito_idx,
  output logic [$clog2(MAX_FALHAS+1)-1:0]   falhas,
  output logic [3:0]                        disp,
  output logic                              disp_valido
);

  localparam int FW = $clog2(MAX_FALHAS + 1);
  localparam int DW = $clog2(DEBOUNCE + 2);
  localparam int TW = (T_BLOQUEIO > 1) ? $clog2(T_BLOQUEIO) : 1;
  localparam int CW = 4 * N_DIGITOS;

  typedef enum logic [2:0] {
    OCIOSO,
    ENTRADA,
    ABERTO,
    PROG,
    BLOQUEADO
  } estado_t;

  logic          insere_meta, insere_sync;
  logic          programa_meta, programa_sync;
  logic [DW-1:0] deb_cnt;
  logic          press;

  estado_t       estado, estado_nxt;
  logic [CW-1:0] codigo, codigo_nxt;
  logic [CW-1:0] sombra, sombra_nxt;
  logic [CW-1:0] codigo_desl;
  logic [TW-1:0] timer, timer_nxt;
  logic          falha_flag, falha_flag_nxt;
  logic          falha_atual;
  logic [2:0]    digito_idx_nxt;
  logic [FW-1:0] falhas_nxt;
  logic [3:0]    disp_nxt;
  logic          disp_valido_nxt;
  logic          erro_nxt;
  logic          invalido_nxt;
  logic          digito_ok;
  logic          ultimo;
  logic [3:0]    slot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      insere_meta   <= 1'b1;
      insere_sync   <= 1'b1;
      programa_meta <= 1'b1;
      programa_sync <= 1'b1;
    end else begin
      insere_meta   <= insere;
      insere_sync   <= insere_meta;
      programa_meta <= programa;
      programa_sync <= programa_meta;
    end
  end

  // Counter parks at DEBOUNCE+1 so a held button yields one press until released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_cnt <= '0;
    end else if (insere_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DW'(DEBOUNCE + 1)) begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign press = (deb_cnt == DW'(DEBOUNCE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado      <= OCIOSO;
      codigo      <= SENHA_INICIAL;
      sombra      <= '0;
      timer       <= '0;
      falha_flag  <= 1'b0;
      digito_idx  <= '0;
      falhas      <= '0;
      disp        <= '0;
      disp_valido <= 1'b0;
      erro        <= 1'b0;
      invalido    <= 1'b0;
    end else begin
      estado      <= estado_nxt;
      codigo      <= codigo_nxt;
      sombra      <= sombra_nxt;
      timer       <= timer_nxt;
      falha_flag  <= falha_flag_nxt;
      digito_idx  <= digito_idx_nxt;
      falhas      <= falhas_nxt;
      disp        <= disp_nxt;
      disp_valido <= disp_valido_nxt;
      erro        <= erro_nxt;
      invalido    <= invalido_nxt;
    end
  end

  // Code slot for the current position: first digit lives in the top nibble.
  assign codigo_desl = codigo << (4 * digito_idx);
  assign slot        = codigo_desl[CW-1 -: 4];
  assign digito_ok   = (numero <= 4'd9);
  assign ultimo      = (digito_idx == 3'(N_DIGITOS - 1));
  assign falha_atual = falha_flag | (numero != slot);

  always_comb begin
    estado_nxt      = estado;
    codigo_nxt      = codigo;
    sombra_nxt      = sombra;
    timer_nxt       = timer;
    falha_flag_nxt  = falha_flag;
    digito_idx_nxt  = digito_idx;
    falhas_nxt      = falhas;
    disp_nxt        = disp;
    disp_valido_nxt = disp_valido;
    erro_nxt        = erro;
    invalido_nxt    = 1'b0;

    case (estado)
      OCIOSO, ENTRADA: begin
        if (press) begin
          if (!digito_ok) begin
            invalido_nxt = 1'b1;
          end else begin
            erro_nxt = 1'b0;
            disp_nxt = numero;
            if (ultimo) begin
              digito_idx_nxt  = '0;
              falha_flag_nxt  = 1'b0;
              disp_valido_nxt = 1'b0;
              if (!falha_atual) begin
                estado_nxt = ABERTO;
                falhas_nxt = '0;
              end else if (int'(falhas) + 1 < MAX_FALHAS) begin
                estado_nxt = OCIOSO;
                falhas_nxt = falhas + FW'(1);
                erro_nxt   = 1'b1;
              end else begin
                estado_nxt = BLOQUEADO;
                falhas_nxt = FW'(MAX_FALHAS);
                timer_nxt  = TW'(T_BLOQUEIO - 1);
              end
            end else begin
              estado_nxt      = ENTRADA;
              digito_idx_nxt  = digito_idx + 3'd1;
              falha_flag_nxt  = falha_atual;
              disp_valido_nxt = 1'b1;
            end
          end
        end
      end

      ABERTO: begin
        if (press) begin
          if (!digito_ok) begin
            invalido_nxt = 1'b1;
          end else begin
            erro_nxt       = 1'b0;
            digito_idx_nxt = '0;
            estado_nxt     = programa_sync ? OCIOSO : PROG;
          end
        end
      end

      PROG: begin
        if (press) begin
          if (!digito_ok) begin
            invalido_nxt = 1'b1;
          end else begin
            erro_nxt   = 1'b0;
            sombra_nxt = {sombra[CW-5:0], numero};
            if (ultimo) begin
              codigo_nxt     = {sombra[CW-5:0], numero};
              digito_idx_nxt = '0;
              estado_nxt     = OCIOSO;
            end else begin
              digito_idx_nxt = digito_idx + 3'd1;
            end
          end
        end
      end

      BLOQUEADO: begin
        erro_nxt = 1'b0;
        if (timer == '0) begin
          estado_nxt = OCIOSO;
          falhas_nxt = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end

      default: estado_nxt = OCIOSO;
    endcase
  end

  assign aberto      = (estado == ABERTO);
  assign bloqueado   = (estado == BLOQUEADO);
  assign programando = (estado == PROG);

endmodule

// File: doc/controle_senha.md
# controle_senha

Sequencing controller for the keypad-and-button combination lock. It conditions the raw `insere` push-button into single accepted key presses and sequences six-digit entry attempts against a programmable code register. It counts failed attempts and enforces a timed lockout, and supports reprogramming the code while unlocked. Its status and last-digit outputs feed the board LEDs and the existing 7-segment decoder.

## Interface
Parameters:
- `N_DIGITOS`, 6: digits per code.
- `SENHA_INICIAL`, 24'h590981: code loaded at reset; first digit in bits [23:20], last in [3:0].
- `MAX_FALHAS`, 3: consecutive wrong attempts that trigger lockout.
- `T_BLOQUEIO`, 50_000_000: lockout length in clock cycles.
- `DEBOUNCE`, 250_000: consecutive low samples required to accept a press.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low; dominates every other input.
- `insere`, in, 1: push-button, active-low, asynchronous to `clk`.
- `programa`, in, 1: program-mode switch, active-low, asynchronous.
- `numero`, in, 4 (`[4:1]`): BCD digit switches.
- `aberto`, out, 1: lock open.
- `bloqueado`, out, 1: lockout in progress.
- `erro`, out, 1: last attempt wrong.
- `programando`, out, 1: collecting a new code.
- `invalido`, out, 1: one-cycle pulse on a press with `numero` > 9.
- `digito_idx`, out, 3: digits accepted in the current entry, 0..N_DIGITOS-1.
- `falhas`, out, $clog2(MAX_FALHAS+1): consecutive wrong attempts.
- `disp`, out, 4: last accepted digit, sent to the 7-segment decoder.
- `disp_valido`, out, 1: `disp` holds a digit from the current entry.

## Operation
- **Input conditioning**
  - `insere` and `programa` each pass through a 2-FF synchronizer.
  - The debounce counter increments while synchronized `insere` = 0 and clears when it is 1.
  - The internal `press` pulses once when the counter reaches DEBOUNCE, and again only after `insere` has been seen high.
  - `numero` is sampled on the `press` cycle.
- **Invalid digits:** a press with `numero` ≥ 10 pulses `invalido`. State, `digito_idx`, `disp` and `erro` are unchanged.
- **Any valid press** clears `erro`.
- **OCIOSO / ENTRADA**
  - A valid press compares the digit with code slot `digito_idx` and ORs any mismatch into a sticky flag.
  - It loads `disp`, sets `disp_valido`, and increments `digito_idx`.
  - No mismatch is revealed before the last digit.
  - Last digit, flag clear: go to ABERTO, `aberto` = 1, `falhas` = 0.
  - Last digit, flag set, `falhas` + 1 < MAX_FALHAS: `falhas` increments, `erro` = 1, return to OCIOSO.
  - Last digit, flag set, `falhas` + 1 = MAX_FALHAS: go to BLOQUEADO.
  - On every completed attempt, `digito_idx`, the flag and `disp_valido` clear.
- **ABERTO**
  - Valid press with synchronized `programa` = 1: relock to OCIOSO.
  - Valid press with `programa` = 0: go to PROG, `programando` = 1. The digit is discarded.
- **PROG**
  - Six valid presses fill a shadow register.
  - On the edge accepting the sixth digit, the shadow is copied to the code register, `programando` clears, and the state goes to OCIOSO.
- **BLOQUEADO**
  - `bloqueado` = 1. The timer loads T_BLOQUEIO-1 and decrements each cycle.
  - On the edge where the timer is 0: go to OCIOSO, `falhas` = 0.
  - Presses are ignored. A button held through the whole lockout does not fire on exit.
  - `erro` = 0 while locked out.
- **Reset**
  - All outputs go to 0; state goes to OCIOSO.
  - The code register reloads SENHA_INICIAL.
  - Timer, debounce counter, shadow register and mismatch flag clear.
  - Reset mid-entry, mid-program or mid-lockout aborts the operation with no code-register write.

## Timing
- Edge 0 is the first edge sampling `insere` = 0.
- `press` is high in the cycle after edge DEBOUNCE+1.
- All registered outputs update at edge DEBOUNCE+2. `invalido` is high for exactly that one cycle.
- Lockout: `bloqueado` is high for exactly T_BLOQUEIO cycles. The next press can be accepted in the cycle `bloqueado` falls, provided it is a fresh press.
- Code-register write and the PROG→OCIOSO transition happen on the same edge.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: DEBOUNCE=4, T_BLOQUEIO=20, MAX_FALHAS=3.
- Reset, then press 5,9,0,9,8,1 → `digito_idx` steps 1..5 and `disp` follows each digit. At the sixth press: `aberto` = 1, `digito_idx` = 0, `falhas` = 0, outputs changing at edge 6 after each press.
- Press 5,9,0,9,8,2 → `erro` = 1, `falhas` = 1, `aberto` = 0. The next valid press clears `erro`.
- Three wrong attempts → `bloqueado` = 1 for exactly 20 cycles and presses are ignored. Then `falhas` = 0, and a correct code opens the lock.
- Open the lock, press with `programa` = 0, then press 1,2,3,4,5,6 → `programando` high, then OCIOSO. 5,9,0,9,8,1 now fails; 1,2,3,4,5,6 opens.
- `insere` low for 3 cycles → no press. Held low 100 cycles → exactly one press. `numero` = 4'hC → one-cycle `invalido`, `digito_idx` unchanged.
- `reset` = 0 after 3 entered digits, and again 5 cycles into a lockout → all outputs 0 on the next edge, code reverts to 590981.
